alu_share_arbiter: RTL and testbench

// - Shares one combinational W-bit ALU (bitwise AND/OR slices, adder) among N requesters (fetch PC+4, branch target, execute).
// - Round-robin grant; one operation in flight.
// - Operands and op are registered into the ALU; the result is registered back to the granted requester.
// - Sits between the multicycle control unit's requesters and the ALU datapath.
//

---
 rtl/alu_share_arbiter_pkg.sv | 18 +
 rtl/alu_share_arbiter_rr_picker.sv | 38 +++
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter.
// - ALU op codes understood by the shared ALU (the arbiter only passes them through).
// - FSM state encoding for the arbiter control.
package alu_share_arbiter_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Scans ptr+1, ptr+2, ... (mod N) and reports the first asserted valid bit.
// Ports:
//   valid  [N]   request vector
//   ptr    [IW]  index granted last time (lowest priority this round)
//   onehot [N]   one-hot of the picked index (zero when nothing valid)
//   idx    [IW]  binary picked index
//   any          at least one valid bit
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        // The modulo keeps candidates inside 0..N-1 even when N is not a power of two.
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && valid[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among N requesters with round-robin grants
// and a single operation in flight (IDLE -> EXEC -> RESP -> IDLE).
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/req_ready [N]    request handshake, ready is one-hot and only in IDLE
//   req_a/req_b [N*W]          operands, requester i at [i*W +: W]
//   req_op [N*OPW]             op code, requester i at [i*OPW +: OPW]
//   alu_a/alu_b/alu_op         registered operands/op to the shared ALU
//   alu_result/alu_zero        combinational ALU outputs
//   rsp_valid/rsp_ready [N]    response handshake, one-hot on the granted requester
//   rsp_result/rsp_zero        registered ALU result and zero flag
//   busy                       high whenever the FSM is not IDLE
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int W   = 32,
    parameter int N   = 3,
    parameter int OPW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    input  logic [N*OPW-1:0] req_op,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [W-1:0]     alu_result,
    input  logic             alu_zero,
    output logic [N-1:0]     rsp_valid,
    input  logic [N-1:0]     rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic             rsp_zero,
    output logic             busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt;
    logic          accept;

    logic [N-1:0]   pick_onehot;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [OPW-1:0] sel_op;

    rr_picker #(.N(N), .IW(IW)) u_picker (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Operand mux for the picked requester.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_op = req_op[i*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                // Gated by rst so that no handshake is offered while reset is held.
                if (pick_any && !rst) begin
                    req_ready = pick_onehot;
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = N'(1) << gnt;
                // Only the granted requester's rsp_ready can release the result.
                if (rsp_ready[gnt]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= IW'(N - 1);
            gnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            // Operands stay on the ALU inputs after the operation; they are not cleared.
            if (accept) begin
                alu_a  <= sel_a;
                alu_b  <= sel_b;
                alu_op <= sel_op;
                gnt    <= pick_idx;
                rr_ptr <= pick_idx;
            end
            // The ALU has had the full EXEC cycle to settle on the registered operands.
            if (state == ST_EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int W   = 32;
    localparam int N   = 3;
    localparam int OPW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N*OPW-1:0] req_op;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [OPW-1:0]   alu_op;
    logic [W-1:0]     alu_result;
    logic             alu_zero;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [W-1:0]     rsp_result;
    logic             rsp_zero;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.W(W), .N(N), .OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [OPW-1:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd6:    return a - b;
            3'd7:    return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: return '0;
        endcase
    endfunction

    // Shared ALU attached to the arbiter.
    assign alu_result = alu_fn(alu_a, alu_b, alu_op);
    assign alu_zero   = (alu_result == '0);

    // First valid index after 'last', scanning modulo N; -1 when none.
    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int d = 1; d <= N; d++) begin
            if (((v >> ((last + d) % N)) & 1) != 0) return (last + d) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] slw(input logic [N*W-1:0] v, input int i);
        return W'(v >> (i * W));
    endfunction

    function automatic logic [OPW-1:0] slo(input logic [N*OPW-1:0] v, input int i);
        return OPW'(v >> (i * OPW));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: either waiting for a grant, or holding one
    // accepted operation that becomes visible as a response one cycle later.
    bit             m_inflight;
    int             m_age;
    int             m_gnt;
    int             m_last;
    logic [W-1:0]   m_a, m_b;
    logic [OPW-1:0] m_op;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_inflight <= 1'b0;
            m_age      <= 0;
            m_gnt      <= 0;
            m_last     <= N - 1;
            m_a        <= '0;
            m_b        <= '0;
            m_op       <= '0;
        end else if (!m_inflight) begin
            if (pick(req_valid, m_last) >= 0) begin
                m_inflight <= 1'b1;
                m_age      <= 0;
                m_gnt      <= pick(req_valid, m_last);
                m_last     <= pick(req_valid, m_last);
                m_a        <= slw(req_a, pick(req_valid, m_last));
                m_b        <= slw(req_b, pick(req_valid, m_last));
                m_op       <= slo(req_op, pick(req_valid, m_last));
            end
        end else if (m_age == 0) begin
            m_age <= 1;
        end else if (rsp_ready[m_gnt]) begin
            m_inflight <= 1'b0;
        end
    end

    logic [N-1:0] e_ready, e_rv;
    int           e_pick;

    always @(negedge clk) begin
        e_pick  = pick(req_valid, m_last);
        e_ready = (!rst && !m_inflight && e_pick >= 0) ? N'(1) << e_pick : '0;
        e_rv    = (!rst && m_inflight && m_age >= 1) ? N'(1) << m_gnt : '0;
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        chk("busy", 64'(busy), 64'(!rst && m_inflight));
        chk("alu_a", 64'(alu_a), 64'(m_a));
        chk("alu_b", 64'(alu_b), 64'(m_b));
        chk("alu_op", 64'(alu_op), 64'(m_op));
        if (e_rv != '0) begin
            chk("rsp_result", 64'(rsp_result), 64'(alu_fn(m_a, m_b, m_op)));
            chk("rsp_zero", 64'(rsp_zero), 64'(alu_fn(m_a, m_b, m_op) == '0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [OPW-1:0] op);
        req_a[i*W +: W]     = a;
        req_b[i*W +: W]     = b;
        req_op[i*OPW +: OPW] = op;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            set_req(i, $urandom, ($urandom_range(0, 3) == 0) ? '0 : $urandom,
                    OPW'($urandom_range(0, 7)));
        end
    endtask

    int           order[$];
    int           when[$];
    int           g;
    logic [W-1:0] held;
    bit           found;
    bit           multi;

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = '0;
        rand_ops();
        step();
        step();
        #2;
        chk("reset_ready", 64'(req_ready), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_alu_a", 64'(alu_a), 64'(0));
        step();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '1;

        // Single request, AND
        step();
        req_valid = 3'b001;
        set_req(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd0);
        #2;
        chk("single_ready", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = '0;
        step();
        #2;
        chk("single_rsp_valid", 64'(rsp_valid), 64'(3'b001));
        chk("single_result", 64'(rsp_result), 64'(32'hF000_F000));
        chk("single_zero", 64'(rsp_zero), 64'(0));
        step();

        // Zero flag
        req_valid = 3'b001;
        set_req(0, 32'hAAAA_AAAA, 32'h5555_5555, 3'd0);
        step();
        req_valid = '0;
        step();
        #2;
        chk("zero_result", 64'(rsp_result), 64'(0));
        chk("zero_flag", 64'(rsp_zero), 64'(1));
        step();

        // Continuous round robin from reset
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = '1;
        multi     = 1'b0;
        for (int c = 0; c < 18; c++) begin
            rand_ops();
            #2;
            if ($countones(req_ready) > 1) multi = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    order.push_back(i);
                    when.push_back(c);
                end
            end
            step();
        end
        chk("rr_count", 64'(order.size()), 64'(6));
        chk("rr_multi", 64'(multi), 64'(0));
        for (int k = 0; k < 6 && k < order.size(); k++) begin
            chk("rr_order", 64'(order[k]), 64'(k % 3));
            chk("rr_spacing", 64'(when[k]), 64'(3 * k));
        end

        // Response backpressure
        rsp_ready = '0;
        found     = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            #2;
            if (rsp_valid != '0) found = 1'b1;
            else step();
        end
        chk("bp_rsp_seen", 64'(found), 64'(1));
        held = rsp_result;
        g    = 0;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) g = i;
        for (int c = 0; c < 5; c++) begin
            step();
            #2;
            chk("bp_result_stable", 64'(rsp_result), 64'(held));
            chk("bp_busy", 64'(busy), 64'(1));
            chk("bp_no_ready", 64'(req_ready), 64'(0));
        end
        step();
        rsp_ready = '1;
        step();
        #2;
        chk("bp_next_grant", 64'(req_ready), 64'(N'(1) << ((g + 1) % N)));

        // Reset during EXEC
        step();
        #2;
        chk("mid_in_exec", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_busy", 64'(busy), 64'(0));
        chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_ready", 64'(req_ready), 64'(0));
        step();
        rst = 1'b0;
        #2;
        chk("mid_first_grant", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = '0;
        repeat (3) step();

        // Wrap-around: last grant 2, then 3'b101
        req_valid = 3'b100;
        #2;
        chk("wrap_pre", 64'(req_ready), 64'(3'b100));
        step();
        req_valid = '0;
        repeat (3) step();
        req_valid = 3'b101;
        #2;
        chk("wrap_first", 64'(req_ready), 64'(3'b001));
        repeat (3) step();
        #2;
        chk("wrap_second", 64'(req_ready), 64'(3'b100));
        step();

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            rand_ops();
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
